// File: rtl/multi_line_capture_buffer.sv
// Ping-pong capture of NUM_LINES consecutive sensor lines into two banks.
// One bank is written from the pixel stream while the other is read by (line, column).
module multi_line_capture_buffer #(
  parameter int H         = 752,
  parameter int V         = 480,
  parameter int DATA_W    = 8,
  parameter int NUM_LINES = 4,
  parameter int CNT_W     = 8,
  localparam int LINE_W   = $clog2(V),
  localparam int COL_W    = $clog2(H),
  localparam int RL_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID_DATA,
  input  logic [LINE_W-1:0] CURRENT_LINE,
  input  logic [COL_W-1:0]  CURRENT_COLUMN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [LINE_W-1:0] START_LINE,
  input  logic [RL_W-1:0]   READ_LINE,
  input  logic [COL_W-1:0]  READ_COLUMN,
  input  logic              RELEASE,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              READY_FLAG,
  output logic              CAPTURE_BUSY,
  output logic              OVERRUN_FLAG,
  output logic [CNT_W-1:0]  DROP_COUNT
);

  localparam int BANK_WORDS = NUM_LINES * H;
  localparam int DEPTH      = 2 * BANK_WORDS;
  localparam int ADDR_W     = $clog2(DEPTH);

  localparam logic [1:0] ST_WAIT_OUT = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] start_q, start_d;
  logic              wbank_q, wbank_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [DATA_W-1:0] data_out_q;

  logic              rbank;
  logic              in_start_win;
  logic              in_cap_win;
  logic              col_ok;
  logic              rd_ok;
  logic              wr_en;
  logic              complete;
  logic [LINE_W-1:0] wr_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] mem [DEPTH];

  assign rbank = ~wbank_q;

  // Window membership is computed in int so S+NUM_LINES-1 may exceed V-1 without wrapping.
  assign in_start_win = (int'(CURRENT_LINE) >= int'(START_LINE)) &&
                        (int'(CURRENT_LINE) <  int'(START_LINE) + NUM_LINES);
  assign in_cap_win   = (int'(CURRENT_LINE) >= int'(start_q)) &&
                        (int'(CURRENT_LINE) <  int'(start_q) + NUM_LINES);
  assign col_ok       = int'(CURRENT_COLUMN) < H;
  assign rd_ok        = (int'(READ_LINE) < NUM_LINES) && (int'(READ_COLUMN) < H);

  assign wr_addr = ADDR_W'(int'(wbank_q) * BANK_WORDS + int'(wr_idx) * H + int'(CURRENT_COLUMN));
  assign rd_addr = ADDR_W'(int'(rbank) * BANK_WORDS + int'(READ_LINE) * H + int'(READ_COLUMN));

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    wbank_d   = wbank_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    complete  = 1'b0;

    case (state_q)
      ST_WAIT_OUT: begin
        // Coming out of reset inside a window would give a partial capture; wait for it to pass.
        if (!in_start_win) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (VALID_DATA && (CURRENT_LINE == START_LINE)) begin
          state_d = ST_CAPTURE;
          start_d = START_LINE;
          wr_en   = col_ok;
          wr_idx  = '0;
        end
      end
      ST_CAPTURE: begin
        if (!in_cap_win) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (VALID_DATA && col_ok) begin
          wr_en  = 1'b1;
          wr_idx = CURRENT_LINE - start_q;
        end
      end
      default: state_d = ST_WAIT_OUT;
    endcase

    // A release coincident with completion frees the read bank first, so the publish succeeds.
    if (complete) begin
      if (!ready_q || RELEASE) begin
        wbank_d = ~wbank_q;
        ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + CNT_W'(1);
      end
    end else if (RELEASE) begin
      ready_d = 1'b0;
    end

    busy_d = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_WAIT_OUT;
      start_q   <= '0;
      wbank_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      wbank_q   <= wbank_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) mem[wr_addr] <= DATA_IN;
  end

  // Registered read with synchronous clear maps onto the RAM output register.
  always_ff @(posedge CLK) begin
    if (RESET || !rd_ok) data_out_q <= '0;
    else                 data_out_q <= mem[rd_addr];
  end

  assign DATA_OUT     = data_out_q;
  assign READY_FLAG   = ready_q;
  assign CAPTURE_BUSY = busy_q;
  assign OVERRUN_FLAG = overrun_q;
  assign DROP_COUNT   = drop_q;

endmodule

// File: tb/tb_multi_line_capture_buffer.sv
// Directed bench: instance A (H=8, V=16, 2 lines) covers the main scenarios,
// instance B (H=6, 3 lines) shares the stream to reach out-of-range columns and lines.
module tb_multi_line_capture_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] cur_line = 4'd0;
  logic [2:0] cur_col = 3'd0;
  logic [7:0] data_in = 8'd0;
  logic [3:0] start_line = 4'd3;
  logic       read_line_a = 1'b0;
  logic [1:0] read_line_b = 2'd0;
  logic [2:0] read_col = 3'd0;
  logic       rel = 1'b0;
  logic [7:0] frame_xor = 8'd0;

  logic [7:0] a_dout, b_dout;
  logic       a_ready, a_busy, a_ovr, b_ready, b_busy, b_ovr;
  logic [1:0] a_drop, b_drop;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_line_capture_buffer #(.H(8), .V(16), .DATA_W(8), .NUM_LINES(2), .CNT_W(2)) dut_a (
    .CLK(clk), .RESET(rst), .VALID_DATA(valid), .CURRENT_LINE(cur_line), .CURRENT_COLUMN(cur_col),
    .DATA_IN(data_in), .START_LINE(start_line), .READ_LINE(read_line_a), .READ_COLUMN(read_col),
    .RELEASE(rel), .DATA_OUT(a_dout), .READY_FLAG(a_ready), .CAPTURE_BUSY(a_busy),
    .OVERRUN_FLAG(a_ovr), .DROP_COUNT(a_drop));

  multi_line_capture_buffer #(.H(6), .V(16), .DATA_W(8), .NUM_LINES(3), .CNT_W(2)) dut_b (
    .CLK(clk), .RESET(rst), .VALID_DATA(valid), .CURRENT_LINE(cur_line), .CURRENT_COLUMN(cur_col),
    .DATA_IN(data_in), .START_LINE(start_line), .READ_LINE(read_line_b), .READ_COLUMN(read_col),
    .RELEASE(rel), .DATA_OUT(b_dout), .READY_FLAG(b_ready), .CAPTURE_BUSY(b_busy),
    .OVERRUN_FLAG(b_ovr), .DROP_COUNT(b_drop));

  task automatic drive_pixel(input int l, input int c, input logic v, input logic r);
    cur_line = 4'(l);
    cur_col  = 3'(c);
    data_in  = 8'(l * 16 + c) ^ frame_xor;
    valid    = v;
    rel      = r;
    @(posedge clk);
    #1;
    valid = 1'b0;
    rel   = 1'b0;
  endtask

  task automatic stream_line(input int l, input int c0);
    for (int c = c0; c < 8; c++) drive_pixel(l, c, 1'b1, 1'b0);
  endtask

  task automatic stream_lines(input int first, input int last);
    for (int l = first; l <= last; l++) stream_line(l, 0);
  endtask

  task automatic do_read(input int l, input int c, input int lb);
    read_line_a = 1'(l);
    read_col    = 3'(c);
    read_line_b = 2'(lb);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    valid = 1'b0;
    cur_line = 4'd0;
    cur_col = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    start_line = 4'd3;
    apply_reset();
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_checks++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", a_ovr); end
    n_checks++; if (a_drop !== 2'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", a_drop); end
    n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", a_dout); end
    n_checks++; if (b_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_b: got %h expected 00", b_dout); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    frame_xor = 8'h00;
    stream_lines(0, 2);
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_pre: got %b expected 0", a_busy); end
    drive_pixel(3, 0, 1'b1, 1'b0);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_cap: got %b expected 1", a_busy); end
    stream_line(3, 1);
    stream_line(4, 0);
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_early: got %b expected 0", a_ready); end
    drive_pixel(5, 0, 1'b1, 1'b0);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_rise: got %b expected 1", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", a_busy); end
    stream_line(5, 1);
    stream_lines(6, 15);
    do_read(1, 7, 0);
    n_checks++; if (a_dout !== 8'h47) begin n_fail++; $display("FAIL basic_read_1_7: got %h expected 47", a_dout); end
    do_read(0, 0, 0);
    n_checks++; if (a_dout !== 8'h30) begin n_fail++; $display("FAIL basic_read_0_0: got %h expected 30", a_dout); end
    $display("test_basic done");
  endtask

  task automatic test_hold_drop();
    frame_xor = 8'hFF;
    stream_lines(0, 4);
    drive_pixel(5, 0, 1'b1, 1'b0);
    n_checks++; if (a_ovr !== 1'b1) begin n_fail++; $display("FAIL drop_overrun: got %b expected 1", a_ovr); end
    n_checks++; if (a_drop !== 2'd1) begin n_fail++; $display("FAIL drop_count: got %0d expected 1", a_drop); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b expected 1", a_ready); end
    stream_line(5, 1);
    stream_lines(6, 15);
    do_read(1, 7, 0);
    n_checks++; if (a_dout !== 8'h47) begin n_fail++; $display("FAIL drop_read_1_7: got %h expected 47", a_dout); end
    do_read(0, 3, 0);
    n_checks++; if (a_dout !== 8'h33) begin n_fail++; $display("FAIL drop_read_0_3: got %h expected 33", a_dout); end
    $display("test_hold_drop done");
  endtask

  task automatic test_ping_pong();
    drive_pixel(15, 7, 1'b0, 1'b1);
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL pp_release: got %b expected 0", a_ready); end
    frame_xor = 8'h55;
    stream_lines(0, 15);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL pp_publish: got %b expected 1", a_ready); end
    do_read(1, 7, 0);
    n_checks++; if (a_dout !== 8'h12) begin n_fail++; $display("FAIL pp_read_1_7: got %h expected 12", a_dout); end
    do_read(0, 2, 0);
    n_checks++; if (a_dout !== 8'h67) begin n_fail++; $display("FAIL pp_read_0_2: got %h expected 67", a_dout); end
    frame_xor = 8'hAA;
    stream_lines(0, 4);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL pp_busy: got %b expected 1", a_busy); end
    n_checks++; if (a_dout !== 8'h67) begin n_fail++; $display("FAIL pp_read_during_cap: got %h expected 67", a_dout); end
    drive_pixel(5, 0, 1'b1, 1'b1);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL pp_rel_on_complete_ready: got %b expected 1", a_ready); end
    n_checks++; if (a_drop !== 2'd1) begin n_fail++; $display("FAIL pp_rel_on_complete_drop: got %0d expected 1", a_drop); end
    stream_line(5, 1);
    stream_lines(6, 15);
    do_read(1, 7, 0);
    n_checks++; if (a_dout !== 8'hED) begin n_fail++; $display("FAIL pp_read_new_1_7: got %h expected ed", a_dout); end
    do_read(0, 2, 0);
    n_checks++; if (a_dout !== 8'h98) begin n_fail++; $display("FAIL pp_read_new_0_2: got %h expected 98", a_dout); end
    $display("test_ping_pong done");
  endtask

  task automatic test_reset_mid_capture();
    frame_xor = 8'h0F;
    stream_lines(0, 3);
    drive_pixel(4, 0, 1'b1, 1'b0);
    drive_pixel(4, 1, 1'b1, 1'b0);
    rst = 1'b1;
    drive_pixel(4, 2, 1'b1, 1'b0);
    rst = 1'b0;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", a_ready); end
    n_checks++; if (a_drop !== 2'd0) begin n_fail++; $display("FAIL mid_rst_drop: got %0d expected 0", a_drop); end
    n_checks++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overrun: got %b expected 0", a_ovr); end
    stream_line(4, 3);
    drive_pixel(5, 0, 1'b1, 1'b0);
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_publish: got %b expected 0", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", a_busy); end
    stream_line(5, 1);
    stream_lines(6, 15);
    frame_xor = 8'h3C;
    stream_lines(0, 4);
    drive_pixel(5, 0, 1'b1, 1'b0);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_next_ready: got %b expected 1", a_ready); end
    stream_line(5, 1);
    stream_lines(6, 15);
    do_read(0, 0, 0);
    n_checks++; if (a_dout !== 8'h0C) begin n_fail++; $display("FAIL mid_rst_read_0_0: got %h expected 0c", a_dout); end
    do_read(1, 7, 0);
    n_checks++; if (a_dout !== 8'h7B) begin n_fail++; $display("FAIL mid_rst_read_1_7: got %h expected 7b", a_dout); end
    $display("test_reset_mid_capture done");
  endtask

  task automatic test_edges();
    start_line = 4'd15;
    apply_reset();
    frame_xor = 8'h00;
    stream_lines(0, 15);
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL edge_ready_before_wrap: got %b expected 0", a_ready); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL edge_busy_line15: got %b expected 1", a_busy); end
    drive_pixel(0, 0, 1'b1, 1'b0);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL edge_ready_on_wrap: got %b expected 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL edge_ready_on_wrap_b: got %b expected 1", b_ready); end
    do_read(0, 3, 0);
    n_checks++; if (a_dout !== 8'hF3) begin n_fail++; $display("FAIL edge_read_0_3: got %h expected f3", a_dout); end
    n_checks++; if (b_dout !== 8'hF3) begin n_fail++; $display("FAIL edge_read_0_3_b: got %h expected f3", b_dout); end
    do_read(1, 3, 1);
    n_checks++; if (a_dout !== 8'h7F) begin n_fail++; $display("FAIL edge_old_line1: got %h expected 7f", a_dout); end
    do_read(1, 0, 1);
    n_checks++; if (a_dout !== 8'h7C) begin n_fail++; $display("FAIL edge_old_line1_c0: got %h expected 7c", a_dout); end
    n_checks++; if (b_dout === 8'hF6) begin n_fail++; $display("FAIL edge_col6_written_b: got %h required not f6", b_dout); end
    do_read(1, 1, 1);
    n_checks++; if (b_dout === 8'hF7) begin n_fail++; $display("FAIL edge_col7_written_b: got %h required not f7", b_dout); end
    do_read(0, 6, 0);
    n_checks++; if (b_dout !== 8'h00) begin n_fail++; $display("FAIL edge_read_col_oob_b: got %h expected 00", b_dout); end
    n_checks++; if (a_dout !== 8'hF6) begin n_fail++; $display("FAIL edge_read_0_6: got %h expected f6", a_dout); end
    do_read(0, 5, 0);
    n_checks++; if (b_dout !== 8'hF5) begin n_fail++; $display("FAIL edge_read_0_5_b: got %h expected f5", b_dout); end
    do_read(0, 5, 3);
    n_checks++; if (b_dout !== 8'h00) begin n_fail++; $display("FAIL edge_read_line_oob_b: got %h expected 00", b_dout); end
    $display("test_edges done");
  endtask

  task automatic test_saturation();
    logic [1:0] exp_drop;
    start_line = 4'd3;
    apply_reset();
    frame_xor = 8'h11;
    stream_lines(0, 2);
    for (int c = 0; c < 4; c++) drive_pixel(3, c, 1'b1, 1'b0);
    start_line = 4'd0;
    stream_line(3, 4);
    stream_line(4, 0);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sat_start_change_busy: got %b expected 1", a_busy); end
    drive_pixel(5, 0, 1'b1, 1'b0);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL sat_start_change_ready: got %b expected 1", a_ready); end
    start_line = 4'd3;
    stream_line(5, 1);
    stream_lines(6, 15);
    do_read(0, 5, 0);
    n_checks++; if (a_dout !== 8'h24) begin n_fail++; $display("FAIL sat_read_0_5: got %h expected 24", a_dout); end
    do_read(1, 2, 0);
    n_checks++; if (a_dout !== 8'h53) begin n_fail++; $display("FAIL sat_read_1_2: got %h expected 53", a_dout); end
    for (int k = 0; k < 5; k++) begin
      frame_xor = 8'(8'h22 + k * 8'h11);
      stream_lines(0, 15);
      exp_drop = (k < 3) ? 2'(k + 1) : 2'd3;
      n_checks++; if (a_drop !== exp_drop) begin n_fail++; $display("FAIL sat_drop_%0d: got %0d expected %0d", k, a_drop, exp_drop); end
      n_checks++; if (b_drop !== exp_drop) begin n_fail++; $display("FAIL sat_drop_b_%0d: got %0d expected %0d", k, b_drop, exp_drop); end
    end
    n_checks++; if (a_ovr !== 1'b1) begin n_fail++; $display("FAIL sat_overrun: got %b expected 1", a_ovr); end
    do_read(1, 2, 0);
    n_checks++; if (a_dout !== 8'h53) begin n_fail++; $display("FAIL sat_read_kept: got %h expected 53", a_dout); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_drop();
    test_ping_pong();
    test_reset_mid_capture();
    test_edges();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
